// File: rtl/led_frame_buffer_pkg.sv
// Shared display definitions for the LED frame buffer:
// bank select encodings, frame geometry and blink timing default.
package led_frame_buffer_pkg;

    typedef enum logic {
        SEL_DATA  = 1'b0,
        SEL_BLINK = 1'b1
    } bank_sel_e;

    localparam int FRAME_BYTES = 8;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;

    localparam int unsigned DEFAULT_BLINK_DIV = 32'd25000000;

    function automatic logic [FRAME_BITS-1:0] set_byte(
        input logic [FRAME_BITS-1:0] frame,
        input logic [2:0]            idx,
        input logic [7:0]            value
    );
        logic [FRAME_BITS-1:0] res;
        res = frame;
        res[{idx, 3'b000} +: 8] = value;
        return res;
    endfunction

endpackage

// File: rtl/led_frame_buffer_blink_timer.sv
// Free-running blink timer: counts 0..BLINK_DIV-1 and toggles
// its phase output each time the count wraps.
module blink_timer
    import led_frame_buffer_pkg::*;
#(
    parameter int unsigned BLINK_DIV = DEFAULT_BLINK_DIV
) (
    input  logic clk,
    input  logic resetn,
    output logic phase
);

    localparam logic [31:0] LAST = 32'(BLINK_DIV - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
        if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store: shadow banks are published to the
// active banks only on a serializer frame edge, with tear-free blinking.
module led_frame_buffer
    import led_frame_buffer_pkg::*;
#(
    parameter int unsigned BLINK_DIV = DEFAULT_BLINK_DIV
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    input  logic        frame_done,
    output logic        busy,
    output logic        commit_done,
    output logic [31:0] data_0,
    output logic [31:0] data_1
);

    logic [FRAME_BITS-1:0] sh_data_q, sh_data_d;
    logic [FRAME_BITS-1:0] sh_blink_q, sh_blink_d;
    logic [FRAME_BITS-1:0] act_data_q, act_data_d;
    logic [FRAME_BITS-1:0] act_blink_q, act_blink_d;
    logic [FRAME_BITS-1:0] disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  commit_done_q, commit_done_d;
    logic                  fd_q, fd_d;
    logic                  frame_phase_q, frame_phase_d;
    logic                  blink_phase;
    logic                  frame_edge;
    logic                  apply;

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_timer (
        .clk   (clk),
        .resetn(resetn),
        .phase (blink_phase)
    );

    always_comb begin
        frame_edge    = frame_done & ~fd_q;
        apply         = frame_edge & pending_q;
        sh_data_d     = sh_data_q;
        sh_blink_d    = sh_blink_q;
        act_data_d    = act_data_q;
        act_blink_d   = act_blink_q;
        pending_d     = pending_q;
        commit_done_d = apply;
        fd_d          = frame_done;
        frame_phase_d = frame_phase_q;

        if (wr_en) begin
            if (bank_sel_e'(wr_sel) == SEL_BLINK)
                sh_blink_d = set_byte(sh_blink_q, wr_addr, wr_data);
            else
                sh_data_d = set_byte(sh_data_q, wr_addr, wr_data);
        end

        // Copy reads the pre-write shadow; a same-cycle write waits for the next commit.
        if (apply) begin
            act_data_d  = sh_data_q;
            act_blink_d = sh_blink_q;
            pending_d   = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end

        if (frame_edge)
            frame_phase_d = blink_phase;

        disp_d = act_data_q & ~(act_blink_q & {FRAME_BITS{frame_phase_q}});
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_data_q     <= '0;
            sh_blink_q    <= '0;
            act_data_q    <= '0;
            act_blink_q   <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            fd_q          <= 1'b0;
            frame_phase_q <= 1'b0;
        end else begin
            sh_data_q     <= sh_data_d;
            sh_blink_q    <= sh_blink_d;
            act_data_q    <= act_data_d;
            act_blink_q   <= act_blink_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            commit_done_q <= commit_done_d;
            fd_q          <= fd_d;
            frame_phase_q <= frame_phase_d;
        end
    end

    assign busy        = pending_q;
    assign commit_done = commit_done_q;
    assign data_0      = disp_q[63:32];
    assign data_1      = disp_q[31:0];

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: vector table for the basic commit,
// hand sequences for frame-edge, blink and reset corner cases.
module tb_led_frame_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit;
    logic        frame_done;
    logic        busy;
    logic        commit_done;
    logic [31:0] data_0;
    logic [31:0] data_1;

    int checks   = 0;
    int failures = 0;

    int   e_cnt = 0;
    logic m_fp = 1'b0;
    logic m_fp_prev = 1'b0;
    logic m_fd_prev = 1'b0;

    typedef struct {
        logic        wr_en;
        logic        wr_sel;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic        commit;
        logic        fd;
        logic        busy;
        logic        cd;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    led_frame_buffer #(
        .BLINK_DIV(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .frame_done (frame_done),
        .busy       (busy),
        .commit_done(commit_done),
        .data_0     (data_0),
        .data_1     (data_1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'd0;
        commit     = 1'b0;
        frame_done = 1'b0;
    endtask

    // Spec-level blink model: phase flips every 4 post-reset edges,
    // frame phase latches it on frame_done rising edges.
    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            e_cnt     = 0;
            m_fp      = 1'b0;
            m_fp_prev = 1'b0;
            m_fd_prev = 1'b0;
        end else begin
            m_fp_prev = m_fp;
            if (frame_done && !m_fd_prev)
                m_fp = ((e_cnt / 4) % 2) == 1;
            m_fd_prev = frame_done;
            e_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic wr(input logic sel, input logic [2:0] a,
                      input logic [7:0] d);
        idle();
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = a;
        wr_data = d;
        tick();
        idle();
    endtask

    task automatic fd_pulse();
        idle();
        frame_done = 1'b1;
        tick();
        idle();
        tick();
    endtask

    initial begin
        int toggles;
        logic [7:0] last_lo;

        for (int k = 0; k < 8; k++)
            vt[k] = '{1'b1, 1'b0, 3'(k), 8'(k + 1), 1'b0, 1'b0,
                      1'b0, 1'b0, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 3'd0, 8'h0, 1'b1, 1'b0,
                   1'b1, 1'b0, 32'h0, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0,
                   1'b1, 1'b0, 32'h0, 32'h0};
        vt[10] = '{1'b0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b1,
                   1'b0, 1'b1, 32'h0, 32'h0};
        vt[11] = '{1'b0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 32'h08070605, 32'h04030201};
        vt[12] = '{1'b0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 32'h08070605, 32'h04030201};

        idle();
        resetn = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cd", commit_done, 0);
        chk("rst_d0", data_0, 0);
        chk("rst_d1", data_1, 0);
        resetn = 1'b1;

        // Basic commit from vector table
        for (int i = 0; i < 13; i++) begin
            wr_en      = vt[i].wr_en;
            wr_sel     = vt[i].wr_sel;
            wr_addr    = vt[i].addr;
            wr_data    = vt[i].data;
            commit     = vt[i].commit;
            frame_done = vt[i].fd;
            tick();
            chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("v%0d_cd", i), commit_done, vt[i].cd);
            chk($sformatf("v%0d_d0", i), data_0, vt[i].d0);
            chk($sformatf("v%0d_d1", i), data_1, vt[i].d1);
        end
        idle();

        // Writes without commit never reach the display
        do_reset();
        for (int k = 0; k < 8; k++)
            wr(1'b0, 3'(k), 8'hFF);
        for (int i = 0; i < 9; i++) begin
            idle();
            frame_done = (i % 3 == 0);
            tick();
            chk("nocommit_d0", data_0, 0);
            chk("nocommit_d1", data_1, 0);
            chk("nocommit_cd", commit_done, 0);
        end

        // Commit coinciding with a frame edge waits for the next edge
        do_reset();
        wr(1'b0, 3'd0, 8'h5A);
        commit     = 1'b1;
        frame_done = 1'b1;
        tick();
        idle();
        chk("same_busy", busy, 1);
        chk("same_cd", commit_done, 0);
        tick();
        chk("same_cd2", commit_done, 0);
        chk("same_d1a", data_1, 0);
        tick();
        chk("same_d1b", data_1, 0);
        frame_done = 1'b1;
        tick();
        idle();
        chk("same_cd3", commit_done, 1);
        chk("same_busy2", busy, 0);
        tick();
        chk("same_d1c", data_1, 32'h0000005A);
        chk("same_cd4", commit_done, 0);

        // Late write joins the pending commit; same-cycle write does not
        do_reset();
        commit = 1'b1;
        tick();
        idle();
        chk("late_busy", busy, 1);
        wr(1'b0, 3'd2, 8'hAA);
        wr_en      = 1'b1;
        wr_addr    = 3'd3;
        wr_data    = 8'h55;
        frame_done = 1'b1;
        tick();
        idle();
        chk("late_cd", commit_done, 1);
        tick();
        chk("late_d1", data_1, 32'h00AA0000);
        commit = 1'b1;
        tick();
        idle();
        fd_pulse();
        chk("late_d1b", data_1, 32'h55AA0000);

        // Reset while a commit is pending
        do_reset();
        wr(1'b0, 3'd0, 8'h11);
        commit = 1'b1;
        tick();
        fd_pulse();
        chk("rp_first", data_1, 32'h00000011);
        wr(1'b0, 3'd0, 8'h22);
        commit = 1'b1;
        tick();
        idle();
        chk("rp_busy", busy, 1);
        resetn  = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'h33;
        commit  = 1'b1;
        tick();
        idle();
        resetn = 1'b1;
        chk("rp_busy0", busy, 0);
        chk("rp_cd0", commit_done, 0);
        chk("rp_d0", data_0, 0);
        chk("rp_d1", data_1, 0);
        for (int i = 0; i < 6; i++) begin
            frame_done = (i % 3 == 0);
            tick();
            chk("rp_cd", commit_done, 0);
            chk("rp_busy", busy, 0);
            chk("rp_d1x", data_1, 0);
        end
        idle();
        commit = 1'b1;
        tick();
        fd_pulse();
        chk("rp_shadow", data_1, 0);

        // Blink with BLINK_DIV=4, frame every 3 cycles
        do_reset();
        for (int k = 0; k < 8; k++)
            wr(1'b0, 3'(k), 8'hFF);
        wr(1'b1, 3'd0, 8'hFF);
        commit = 1'b1;
        tick();
        toggles = 0;
        last_lo = 8'hFF;
        for (int i = 0; i < 36; i++) begin
            idle();
            frame_done = (i % 3 == 0);
            tick();
            if (i == 0)
                chk("blink_cd", commit_done, 1);
            else begin
                chk("blink_d0", data_0, 32'hFFFFFFFF);
                chk("blink_d1", data_1,
                    m_fp_prev ? 32'hFFFFFF00 : 32'hFFFFFFFF);
                if (data_1[7:0] != last_lo)
                    toggles++;
                last_lo = data_1[7:0];
            end
        end
        idle();
        chk("blink_toggles", 32'(toggles >= 2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_frame_buffer.md
LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (legal range 2..2^32-1).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port wr_en  input  1  byte write strobe, one write per cycle high.
REQ-005 SHALL have port wr_sel  input  1  target bank: 0 = pixel data, 1 = blink mask.
REQ-006 SHALL have port wr_addr  input  3  byte index; byte k maps to frame bits [8k+7:8k].
REQ-007 SHALL have port wr_data  input  8  byte written.
REQ-008 SHALL have port commit  input  1  request to publish shadow banks to display.
REQ-009 SHALL have port frame_done  input  1  storage-latch pulse from the downstream 595 serializer.
REQ-010 SHALL have port busy  output  1  high while a commit is pending.
REQ-011 SHALL have port commit_done  output  1  one-cycle pulse when a commit is applied.
REQ-012 SHALL have port data_0  output  32  display bits [63:32] to serializer chain 0.
REQ-013 SHALL have port data_1  output  32  display bits [31:0] to serializer chain 1.

Function
REQ-014 SHALL hold two 64-bit shadow banks (data, blink) and two 64-bit active banks.
REQ-015 SHALL update the selected shadow byte at the clock edge where wr_en=1; no latency beyond that edge, no backpressure.
REQ-016 SHALL detect frame edge as frame_done=1 while its previous-cycle registered value was 0; a held-high frame_done yields one edge.
REQ-017 SHALL set pending (busy=1) on the edge after commit=1; commit while pending is absorbed, no second commit queued.
REQ-018 SHALL, on a frame edge with pending already 1, copy both shadow banks to active banks, clear pending, pulse commit_done for exactly that next cycle.
REQ-019 SHALL NOT apply a commit on a frame edge coinciding with the commit cycle itself; copy waits for the following frame edge.
REQ-020 SHALL copy pre-write shadow contents when a write and the copy occur in the same cycle; the write lands in shadow only.
REQ-021 SHALL include in a pending commit all shadow writes made before the applying frame edge.
REQ-022 SHALL never change active banks except at a frame edge with pending=1.
REQ-023 SHALL run a blink counter 0..BLINK_DIV-1, wrapping to 0 and toggling blink_phase on wrap.
REQ-024 SHALL latch blink_phase into frame_phase only on frame edges, so a frame is never torn.
REQ-025 SHALL compute display = active_data AND NOT (active_blink AND {64{frame_phase}}), registered; data_0/data_1 reflect it one cycle after active/frame_phase change.
REQ-026 SHALL use frame_phase and active banks from the same edge (committed blink mask takes effect in the same frame as committed data).

Reset
REQ-027 SHALL, with resetn=0 at a clock edge, clear all four banks, pending, blink counter, blink_phase, frame_phase, frame_done history.
REQ-028 SHALL drive busy=0, commit_done=0, data_0=0, data_1=0 the cycle after reset; a mid-commit reset discards the pending commit.
REQ-029 SHALL ignore wr_en and commit while resetn=0.

Structure
REQ-030 SHALL place bank select encodings (SEL_DATA=0, SEL_BLINK=1), FRAME_BYTES=8 and default BLINK_DIV in the shared display package.
REQ-031 SHALL implement the counter and phase toggle as one sub-module, blink_timer, parameterised by BLINK_DIV.

Verification
REQ-032 SHALL test: write bytes 0..7 = 0x01..0x08 bank 0, commit, frame_done pulse -> data_1=0x04030201, data_0=0x08070605, commit_done one pulse, busy 1->0.
REQ-033 SHALL test: write without commit across 3 frame_done pulses -> data_0/data_1 stay 0, commit_done never asserted.
REQ-034 SHALL test: commit and frame_done same cycle -> no copy; copy on next frame_done pulse only.
REQ-035 SHALL test: BLINK_DIV=4, data all ones, blink byte 0 = 0xFF, frame_done every 3 cycles -> data_1[7:0] alternates 0xFF/0x00 only at frame edges, other bits stay 1.
REQ-036 SHALL test: commit, then write byte 2 = 0xAA before frame_done -> committed frame contains 0xAA at bits [23:16].
REQ-037 SHALL test: commit pending, resetn low one cycle -> busy=0, outputs 0, later frame_done produces no commit_done.
